// File: rtl/eth_notify_tx.sv
// eth_notify_tx: turns one {key, flag} lookup result into a fixed 60-byte UDP/IPv4
// notification frame on a 64-bit AXI-Stream master (byte k of a beat on tdata[8k+7:8k]).
//
// Ports:
//   clk156, eth_rst_n         clock, asynchronous active-low reset
//   req_valid/req_ready       request handshake; ready only while idle
//   req_key, req_flag         key (MSB first on the wire) and 4-bit DB flag
//   m_axis_t*                 AXIS master; 8 beats, last beat keeps 4 bytes
//   busy                      high whenever not idle
//   frame_cnt                 completed frames, wraps at 16 bits
module eth_notify_tx #(
  parameter int unsigned KEY_SIZE   = 96,
  parameter logic [47:0] SRC_MAC    = 48'h001122334455,
  parameter logic [47:0] DST_MAC    = 48'h90e2ba5d91d1,
  parameter logic [31:0] SRC_IP     = 32'hc0a80164,
  parameter logic [31:0] DST_IP     = 32'hc0a80162,
  parameter logic [15:0] SRC_PORT   = 16'd12345,
  parameter logic [15:0] DST_PORT   = 16'd12346,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic                clk156,
  input  logic                eth_rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [KEY_SIZE-1:0] req_key,
  input  logic [3:0]          req_flag,
  input  logic                m_axis_tready,
  output logic                m_axis_tvalid,
  output logic [63:0]         m_axis_tdata,
  output logic [7:0]          m_axis_tkeep,
  output logic                m_axis_tlast,
  output logic                m_axis_tuser,
  output logic                busy,
  output logic [15:0]         frame_cnt
);

  typedef enum logic [2:0] {StIdle, StCsum1, StCsum2, StSend, StGap} state_e;

  localparam logic [15:0] GapLast = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

  state_e                state_q;
  logic [KEY_SIZE-1:0]   key_q;
  logic [3:0]            flag_q;
  logic [15:0]           id_q;       // ID for the next frame
  logic [15:0]           id_lat_q;   // ID of the frame in flight
  logic [31:0]           sum_q;
  logic [15:0]           csum_q;
  logic [2:0]            beat_q;
  logic [15:0]           gap_cnt_q;
  logic [15:0]           frame_cnt_q;
  logic                  req_ready_q;
  logic                  tvalid_q;
  logic                  tlast_q;
  logic [7:0]            tkeep_q;
  logic [63:0]           tdata_q;

  // Whole frame, network order, byte 0 in the top bits; padded to 64 bytes with zeros.
  logic [511:0] frame;
  assign frame = {DST_MAC, SRC_MAC, 16'h0800,
                  16'h4500, 16'd46, id_lat_q, 16'h4000, 16'h4011, csum_q, SRC_IP, DST_IP,
                  SRC_PORT, DST_PORT, 16'd26, 16'h0000,
                  key_q, 4'h0, flag_q, 72'h0};

  // IPv4 header one's-complement sum with the checksum field taken as zero.
  logic [31:0] hdr_sum;
  assign hdr_sum = 32'h4500 + 32'd46 + {16'h0, id_lat_q} + 32'h4000 + 32'h4011
                 + {16'h0, SRC_IP[31:16]} + {16'h0, SRC_IP[15:0]}
                 + {16'h0, DST_IP[31:16]} + {16'h0, DST_IP[15:0]};

  // Ten 16-bit words cannot exceed 20 bits, so two folds always clear the carry.
  logic [16:0] fold1;
  logic [15:0] fold2;
  assign fold1 = {1'b0, sum_q[15:0]} + {1'b0, sum_q[31:16]};
  assign fold2 = fold1[15:0] + {15'h0, fold1[16]};

  // Beat to present after the next edge: 0 when entering SEND, else the following beat.
  logic [2:0]  nxt_beat;
  logic [63:0] beats_be [8];
  logic [63:0] nxt_be;
  logic [63:0] nxt_data;
  logic [7:0]  nxt_keep;

  assign nxt_beat = (state_q == StSend) ? beat_q + 3'd1 : 3'd0;

  for (genvar b = 0; b < 8; b++) begin : g_beats
    assign beats_be[b] = frame[511 - 64*b -: 64];
  end

  assign nxt_be = beats_be[nxt_beat];

  // First wire byte goes to lane 0.
  for (genvar j = 0; j < 8; j++) begin : g_lanes
    assign nxt_data[8*j +: 8] = nxt_be[63 - 8*j -: 8];
  end

  assign nxt_keep = (nxt_beat == 3'd7) ? 8'h0F : 8'hFF;

  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      state_q     <= StIdle;
      key_q       <= '0;
      flag_q      <= '0;
      id_q        <= '0;
      id_lat_q    <= '0;
      sum_q       <= '0;
      csum_q      <= '0;
      beat_q      <= '0;
      gap_cnt_q   <= '0;
      frame_cnt_q <= '0;
      req_ready_q <= 1'b0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tkeep_q     <= '0;
      tdata_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid && req_ready_q) begin
            key_q       <= req_key;
            flag_q      <= req_flag;
            id_lat_q    <= id_q;
            req_ready_q <= 1'b0;
            state_q     <= StCsum1;
          end else begin
            // Ready rises on the first edge after reset release.
            req_ready_q <= 1'b1;
          end
        end
        StCsum1: begin
          sum_q   <= hdr_sum;
          state_q <= StCsum2;
        end
        StCsum2: begin
          // Beat 0 holds only MAC addresses, so the old csum_q in frame is harmless here.
          csum_q   <= ~fold2;
          beat_q   <= 3'd0;
          tvalid_q <= 1'b1;
          tdata_q  <= nxt_data;
          tkeep_q  <= nxt_keep;
          tlast_q  <= 1'b0;
          state_q  <= StSend;
        end
        StSend: begin
          if (m_axis_tready) begin
            if (beat_q == 3'd7) begin
              tvalid_q    <= 1'b0;
              tlast_q     <= 1'b0;
              tkeep_q     <= '0;
              tdata_q     <= '0;
              frame_cnt_q <= frame_cnt_q + 16'd1;
              id_q        <= id_q + 16'd1;
              if (GAP_CYCLES == 0) begin
                req_ready_q <= 1'b1;
                state_q     <= StIdle;
              end else begin
                gap_cnt_q <= GapLast;
                state_q   <= StGap;
              end
            end else begin
              beat_q  <= nxt_beat;
              tdata_q <= nxt_data;
              tkeep_q <= nxt_keep;
              tlast_q <= (nxt_beat == 3'd7);
            end
          end
        end
        StGap: begin
          if (gap_cnt_q == 16'd0) begin
            req_ready_q <= 1'b1;
            state_q     <= StIdle;
          end else begin
            gap_cnt_q <= gap_cnt_q - 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = 1'b0;
  assign busy          = (state_q != StIdle);
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_eth_notify_tx.sv
// Bench for eth_notify_tx: one instance with a 4-cycle gap and one with no gap, sharing
// stimulus through a select. Expected frames are built byte by byte from the frame layout.
module tb_eth_notify_tx;

  localparam int unsigned Gap    = 4;
  localparam logic [47:0] SrcMac = 48'h001122334455;
  localparam logic [47:0] DstMac = 48'h90e2ba5d91d1;
  localparam logic [31:0] SrcIp  = 32'hc0a80164;
  localparam logic [31:0] DstIp  = 32'hc0a80162;
  localparam logic [15:0] SrcPort = 16'd12345;
  localparam logic [15:0] DstPort = 16'd12346;

  logic        clk156 = 1'b0;
  logic        eth_rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [95:0] req_key = '0;
  logic [3:0]  req_flag = '0;
  logic        m_axis_tready = 1'b0;
  logic        sel = 1'b0;

  logic        a_ready, a_tvalid, a_tlast, a_tuser, a_busy;
  logic [63:0] a_tdata;
  logic [7:0]  a_tkeep;
  logic [15:0] a_cnt;
  logic        b_ready, b_tvalid, b_tlast, b_tuser, b_busy;
  logic [63:0] b_tdata;
  logic [7:0]  b_tkeep;
  logic [15:0] b_cnt;

  logic        req_ready, tvalid, tlast, tuser, busy;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic [15:0] frame_cnt;

  assign req_ready = sel ? b_ready  : a_ready;
  assign tvalid    = sel ? b_tvalid : a_tvalid;
  assign tlast     = sel ? b_tlast  : a_tlast;
  assign tuser     = sel ? b_tuser  : a_tuser;
  assign busy      = sel ? b_busy   : a_busy;
  assign tdata     = sel ? b_tdata  : a_tdata;
  assign tkeep     = sel ? b_tkeep  : a_tkeep;
  assign frame_cnt = sel ? b_cnt    : a_cnt;

  eth_notify_tx #(.GAP_CYCLES(Gap)) u_dut_gap (
    .clk156        (clk156),
    .eth_rst_n     (eth_rst_n),
    .req_valid     (req_valid && !sel),
    .req_ready     (a_ready),
    .req_key       (req_key),
    .req_flag      (req_flag),
    .m_axis_tready (m_axis_tready),
    .m_axis_tvalid (a_tvalid),
    .m_axis_tdata  (a_tdata),
    .m_axis_tkeep  (a_tkeep),
    .m_axis_tlast  (a_tlast),
    .m_axis_tuser  (a_tuser),
    .busy          (a_busy),
    .frame_cnt     (a_cnt)
  );

  eth_notify_tx #(.GAP_CYCLES(0)) u_dut_nogap (
    .clk156        (clk156),
    .eth_rst_n     (eth_rst_n),
    .req_valid     (req_valid && sel),
    .req_ready     (b_ready),
    .req_key       (req_key),
    .req_flag      (req_flag),
    .m_axis_tready (m_axis_tready),
    .m_axis_tvalid (b_tvalid),
    .m_axis_tdata  (b_tdata),
    .m_axis_tkeep  (b_tkeep),
    .m_axis_tlast  (b_tlast),
    .m_axis_tuser  (b_tuser),
    .busy          (b_busy),
    .frame_cnt     (b_cnt)
  );

  always #5 clk156 = ~clk156;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state, one slot per instance.
  logic [15:0] exp_id  [2] = '{16'd0, 16'd0};
  logic [15:0] exp_cnt [2] = '{16'd0, 16'd0};
  logic [7:0]  fr [64];

  function automatic logic [15:0] ip_csum(input logic [15:0] id);
    logic [15:0] w [10];
    int unsigned s;
    w = '{16'h4500, 16'd46, id, 16'h4000, 16'h4011, 16'h0000,
          SrcIp[31:16], SrcIp[15:0], DstIp[31:16], DstIp[15:0]};
    s = 0;
    for (int i = 0; i < 10; i++) s += 32'(w[i]);
    while ((s >> 16) != 0) s = (s & 32'hffff) + (s >> 16);
    return ~s[15:0];
  endfunction

  task automatic build_frame(input logic [95:0] key, input logic [3:0] flag,
                             input logic [15:0] id);
    logic [15:0] cs;
    cs = ip_csum(id);
    for (int i = 0; i < 64; i++) fr[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      fr[i]     = DstMac[47 - 8*i -: 8];
      fr[6 + i] = SrcMac[47 - 8*i -: 8];
    end
    fr[12] = 8'h08; fr[14] = 8'h45; fr[17] = 8'd46;
    fr[18] = id[15:8]; fr[19] = id[7:0];
    fr[20] = 8'h40; fr[22] = 8'h40; fr[23] = 8'h11;
    fr[24] = cs[15:8]; fr[25] = cs[7:0];
    for (int i = 0; i < 4; i++) begin
      fr[26 + i] = SrcIp[31 - 8*i -: 8];
      fr[30 + i] = DstIp[31 - 8*i -: 8];
    end
    fr[34] = SrcPort[15:8]; fr[35] = SrcPort[7:0];
    fr[36] = DstPort[15:8]; fr[37] = DstPort[7:0];
    fr[39] = 8'd26;
    for (int i = 0; i < 12; i++) fr[42 + i] = key[95 - 8*i -: 8];
    fr[54] = {4'h0, flag};
  endtask

  function automatic logic [63:0] exp_beat(input int b);
    logic [63:0] d;
    for (int j = 0; j < 8; j++) d[8*j +: 8] = fr[8*b + j];
    return d;
  endfunction

  // Issue one request and follow its frame. inject_beat pulses a foreign request during
  // that beat; abort_beat pulls reset while that beat is presented. -1 disables either.
  task automatic run_frame(input logic [95:0] key, input logic [3:0] flag,
                           input int stall_pct, input int inject_beat, input int abort_beat,
                           output logic [63:0] beat3);
    int d, gap, k, cyc, beat;
    bit first, done, stalled, injected;
    logic [63:0] p_data;
    logic [7:0]  p_keep;
    logic        p_last;
    d = sel ? 1 : 0;
    gap = sel ? 0 : int'(Gap);
    beat3 = '0;
    build_frame(key, flag, exp_id[d]);
    k = 0;
    while (!req_ready && k < 100) begin
      @(negedge clk156);
      k++;
    end
    if (!req_ready) begin
      check_eq("req_ready_wait", 64'(req_ready), 64'd1);
      return;
    end
    req_key = key;
    req_flag = flag;
    req_valid = 1'b1;
    @(posedge clk156);
    #1 req_valid = 1'b0;
    cyc = 0; beat = 0; first = 1; done = 0; stalled = 0; injected = 0;
    p_data = '0; p_keep = '0; p_last = 1'b0;
    while (!done && cyc < 400) begin
      @(negedge clk156);
      cyc++;
      if (req_valid) begin
        check_eq("ignored_req_ready", 64'(req_ready), 64'd0);
        req_valid = 1'b0;
      end
      if (tvalid) begin
        if (first) check_eq("first_valid_latency", 64'(cyc), 64'd3);
        first = 0;
        if (stalled) begin
          check_eq("hold_tdata", tdata, p_data);
          check_eq("hold_tkeep", 64'(tkeep), 64'(p_keep));
          check_eq("hold_tlast", 64'(tlast), 64'(p_last));
        end
        check_eq($sformatf("tdata_b%0d", beat), tdata, exp_beat(beat));
        check_eq($sformatf("tkeep_b%0d", beat), 64'(tkeep), (beat == 7) ? 64'h0F : 64'hFF);
        check_eq($sformatf("tlast_b%0d", beat), 64'(tlast), (beat == 7) ? 64'd1 : 64'd0);
        check_eq("tuser", 64'(tuser), 64'd0);
        if (beat == 3) beat3 = tdata;
        if (beat == abort_beat) begin
          #2 eth_rst_n = 1'b0;
          #1;
          check_eq("rst_tvalid_async", 64'(tvalid), 64'd0);
          check_eq("rst_tlast_async", 64'(tlast), 64'd0);
          check_eq("rst_tkeep_async", 64'(tkeep), 64'd0);
          m_axis_tready = 1'b1;
          @(negedge clk156);
          eth_rst_n = 1'b1;
          exp_id = '{16'd0, 16'd0};
          exp_cnt = '{16'd0, 16'd0};
          check_eq("rst_frame_cnt", 64'(frame_cnt), 64'd0);
          check_eq("rst_busy", 64'(busy), 64'd0);
          @(negedge clk156);
          check_eq("rst_ready_after_release", 64'(req_ready), 64'd1);
          return;
        end
        if (beat == inject_beat && !injected) begin
          req_key = ~key;
          req_flag = ~flag;
          req_valid = 1'b1;
          injected = 1;
          check_eq("busy_ready_low", 64'(req_ready), 64'd0);
        end
        m_axis_tready = ($urandom_range(99) >= stall_pct);
        p_data = tdata; p_keep = tkeep; p_last = tlast;
        stalled = !m_axis_tready;
        if (m_axis_tready) begin
          if (beat == 7) done = 1;
          beat++;
        end
      end else begin
        if (!first) check_eq("valid_drop_in_frame", 64'(tvalid), 64'd1);
        m_axis_tready = 1'($urandom_range(1));
      end
    end
    check_eq("frame_complete", 64'(done), 64'd1);
    if (!done) return;
    exp_id[d]++;
    exp_cnt[d]++;
    k = 0;
    do begin
      @(negedge clk156);
      k++;
      if (k == 1) begin
        check_eq("frame_cnt", 64'(frame_cnt), 64'(exp_cnt[d]));
        check_eq("tvalid_after_last", 64'(tvalid), 64'd0);
      end
    end while (!req_ready && k < 50);
    check_eq("ready_after_gap", 64'(k), 64'(gap + 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] b3;
    logic [15:0] cnt_before;
    int seen;

    repeat (3) @(negedge clk156);
    check_eq("reset_tvalid", 64'(tvalid), 64'd0);
    check_eq("reset_tkeep", 64'(tkeep), 64'd0);
    check_eq("reset_tlast", 64'(tlast), 64'd0);
    check_eq("reset_frame_cnt", 64'(frame_cnt), 64'd0);
    check_eq("reset_busy", 64'(busy), 64'd0);
    check_eq("reset_ready_held", 64'(req_ready), 64'd0);
    eth_rst_n = 1'b1;
    @(negedge clk156);
    check_eq("ready_after_release", 64'(req_ready), 64'd1);

    // Known frame, no stalls; checksum for ID 0 is B6A8.
    run_frame(96'h0102030405060708090a0b0c, 4'h5, 0, -1, -1, b3);
    check_eq("beat3_known", b3, 64'ha8c0_6401_a8c0_a8b6);

    // Back-to-back: ID 1, checksum B6A7.
    run_frame({$urandom, $urandom, $urandom}, 4'($urandom), 0, -1, -1, b3);
    check_eq("beat3_csum_id1", 64'(b3[15:0]), 64'h0000_a7b6);

    // Random backpressure.
    for (int i = 0; i < 4; i++) begin
      run_frame({$urandom, $urandom, $urandom}, 4'($urandom), 50, -1, -1, b3);
    end

    // Foreign request during SEND must be ignored.
    cnt_before = frame_cnt;
    run_frame({$urandom, $urandom, $urandom}, 4'($urandom), 30, 2, -1, b3);
    seen = 0;
    repeat (20) begin
      @(negedge clk156);
      if (tvalid) seen++;
    end
    check_eq("no_extra_frame", 64'(seen), 64'd0);
    check_eq("no_extra_cnt", 64'(frame_cnt), 64'(cnt_before + 16'd1));

    // Reset during beat 4, then the next frame restarts at ID 0.
    run_frame({$urandom, $urandom, $urandom}, 4'($urandom), 0, -1, 4, b3);
    run_frame({$urandom, $urandom, $urandom}, 4'($urandom), 0, -1, -1, b3);
    check_eq("beat3_csum_after_rst", 64'(b3[15:0]), 64'h0000_a8b6);

    // Zero-gap instance.
    sel = 1'b1;
    @(negedge clk156);
    run_frame({$urandom, $urandom, $urandom}, 4'($urandom), 0, -1, -1, b3);
    run_frame({$urandom, $urandom, $urandom}, 4'($urandom), 20, -1, -1, b3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
